// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: round-robin arbiter that hands one requester's byte at a time to a single SPI TX engine.
// Defining SPI_ARB_TIMEOUT_EN adds a watchdog that aborts a transfer after TIMEOUT_CYC cycles.
module spi_tx_arbiter #(
   parameter int          NUM_REQ     = 4,
   parameter logic [31:0] TIMEOUT_CYC = 32'd2_000_000
) (
   input  logic        In_clk,
   input  logic        In_rst,
   input  logic [3:0]  In_req,
   input  logic [31:0] In_data,
   output logic [3:0]  Out_gnt,
   output logic [3:0]  Out_done,
   output logic        Out_timeout,
   output logic        Out_busy,
   output logic [1:0]  Out_owner,
   output logic        Out_tx_req,
   output logic [7:0]  Out_tx_data,
   input  logic        In_tx_busy
);
   typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;
   state_t state, state_nxt;
   logic [1:0] ptr, win;
   logic grant, done_fire, timeout_hit;
   always_ff @(posedge In_clk)
      state <= In_rst ? IDLE : state_nxt;
   always_comb
      state_nxt = (state == IDLE)      ? (grant ? WAIT_BUSY : IDLE) :
                  timeout_hit          ? IDLE :
                  (state == WAIT_BUSY) ? (In_tx_busy ? WAIT_DONE : WAIT_BUSY) :
                                         (In_tx_busy ? WAIT_DONE : IDLE);
   always_comb begin
      grant     = state == IDLE && |In_req;
      done_fire = state == WAIT_DONE && !In_tx_busy && !timeout_hit;
      Out_busy  = state != IDLE;
   end
   // smallest offset from ptr wins: scan offsets downward and keep the last hit
   always_comb begin
      win = ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (In_req[ptr + 2'(k)]) win = ptr + 2'(k);
   end
   always_ff @(posedge In_clk)
      if (In_rst) begin
         ptr         <= '0;
         Out_gnt     <= '0;
         Out_done    <= '0;
         Out_owner   <= '0;
         Out_tx_req  <= 1'b0;
         Out_tx_data <= '0;
      end else begin
         Out_gnt    <= grant ? 4'b0001 << win : 4'b0000;
         Out_tx_req <= grant;
         Out_done   <= done_fire ? 4'b0001 << Out_owner : 4'b0000;
         if (grant) begin
            ptr         <= win + 2'd1;
            Out_owner   <= win;
            Out_tx_data <= In_data[8*win +: 8];
         end
      end
`ifdef SPI_ARB_TIMEOUT_EN
   logic [31:0] wd_cnt;
   always_ff @(posedge In_clk)
      if (In_rst || grant) wd_cnt <= '0;
      else if (Out_busy) wd_cnt <= wd_cnt + 32'd1;
   assign timeout_hit = Out_busy && wd_cnt == TIMEOUT_CYC - 32'd1;
   always_ff @(posedge In_clk)
      Out_timeout <= !In_rst && timeout_hit;
`else
   assign timeout_hit = 1'b0;
   assign Out_timeout = 1'b0;
`endif
endmodule

// File: doc/spi_tx_arbiter.md
SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (fixed at 4 in this revision).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 32'd2_000_000, giving the watchdog limit in In_clk cycles.
REQ-003 The block SHALL have port In_clk, input, 1, the single system clock for all logic.
REQ-004 The block SHALL have port In_rst, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port In_req, input, 4, per-requester send request, held high until grant.
REQ-006 The block SHALL have port In_data, input, 32, the byte of requester i on bits [8i+7:8i].
REQ-007 The block SHALL have port Out_gnt, output, 4, a one-cycle pulse to the requester whose byte was captured.
REQ-008 The block SHALL have port Out_done, output, 4, a one-cycle pulse when that requester's byte has finished on the bus.
REQ-009 The block SHALL have port Out_timeout, output, 1, a one-cycle pulse when the watchdog aborts a transfer.
REQ-010 The block SHALL have port Out_busy, output, 1, high whenever the state is not IDLE.
REQ-011 The block SHALL have port Out_owner, output, 2, the index of the current or last granted requester.
REQ-012 The block SHALL have port Out_tx_req, output, 1, the start strobe to the SPI TX engine.
REQ-013 The block SHALL have port Out_tx_data, output, 8, the byte presented to the engine, held stable through the transfer.
REQ-014 The block SHALL have port In_tx_busy, input, 1, the busy flag from the engine.

Function
REQ-015 The block SHALL implement a state machine with states IDLE, WAIT_BUSY and WAIT_DONE.
REQ-016 In IDLE with any In_req bit high, the block SHALL select one winner by round-robin, starting the search at pointer ptr and ascending modulo 4.
REQ-017 On the clock edge that leaves IDLE, the block SHALL:
- register Out_gnt[w]=1, Out_tx_req=1, Out_tx_data=In_data[w] and Out_owner=w;
- set ptr=(w+1) mod 4;
- enter WAIT_BUSY.
REQ-018 Out_gnt and Out_tx_req SHALL be high for exactly one cycle per grant.
REQ-019 Out_tx_data SHALL stay unchanged until the next grant, regardless of changes on In_data.
REQ-020 In WAIT_BUSY, the block SHALL enter WAIT_DONE on the first cycle In_tx_busy=1.
REQ-021 In WAIT_DONE, the block SHALL pulse Out_done[owner] and return to IDLE on the first cycle In_tx_busy=0.
REQ-022 The block SHALL issue a new grant no earlier than the cycle after it returns to IDLE, giving a minimum of 1 idle cycle between engine transfers.
REQ-023 Requests that arrive while the state is not IDLE SHALL be ignored until IDLE; the block SHALL have no request queueing.
REQ-024 If a requester drops In_req before it is granted, the block SHALL NOT grant it.
REQ-025 Simultaneous requests SHALL be resolved only by ptr, and a continuously requesting set SHALL be served in strict rotation with no starvation.
REQ-026 The block SHALL pulse at most one bit of Out_gnt and at most one bit of Out_done per cycle.

Reset
REQ-027 While In_rst=1 at a clock edge, the block SHALL set state=IDLE, ptr=0, Out_gnt=0, Out_done=0, Out_timeout=0, Out_busy=0, Out_owner=0, Out_tx_req=0, Out_tx_data=8'h00, and clear the watchdog counter.
REQ-028 A reset asserted mid-transfer SHALL abort immediately with no Out_done pulse, leaving the engine to finish on its own.
REQ-029 After a mid-transfer reset, the first grant SHALL go to the lowest requesting index starting from 0.

Configuration
REQ-030 Macro SPI_ARB_TIMEOUT_EN defined: the block SHALL count cycles spent in WAIT_BUSY plus WAIT_DONE.
REQ-031 With SPI_ARB_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYC-1, the block SHALL:
- pulse Out_timeout;
- return to IDLE;
- suppress Out_done for that transfer;
- keep ptr as updated at grant.
REQ-032 With SPI_ARB_TIMEOUT_EN defined, the counter SHALL clear on every grant.
REQ-033 Macro SPI_ARB_TIMEOUT_EN undefined: the block SHALL contain no counter and SHALL tie Out_timeout to 0, waiting indefinitely in WAIT_BUSY and WAIT_DONE.

Verification
REQ-034 The bench SHALL cover a single request: In_req=4'b0100, data byte 2=8'hA5 -> Out_gnt=4'b0100, Out_tx_data=8'hA5, Out_tx_req for 1 cycle, Out_done[2] once after engine busy falls.
REQ-035 The bench SHALL cover all four requesting from reset: In_req=4'b1111 held -> grant order 0,1,2,3,0 with exactly one Out_done per grant.
REQ-036 The bench SHALL cover pointer wrap: last grant 3, then In_req=4'b1001 -> grant 0, then grant 3.
REQ-037 The bench SHALL cover a late request: In_req[1] raised during WAIT_DONE of requester 0 -> no grant until IDLE, then Out_gnt=4'b0010.
REQ-038 The bench SHALL cover the watchdog: macro defined, TIMEOUT_CYC=16, In_tx_busy held 0 -> Out_timeout pulses 16 cycles after grant, no Out_done, Out_busy=0 next cycle.
REQ-039 The bench SHALL cover reset mid-transfer: In_rst=1 in WAIT_DONE -> all outputs at reset values on the next cycle, next grant starts search from index 0.
